// File: rtl/track_ingre_ctrl_if.sv
// Control/status bundle between the game sequencer and the falling-ingredient
// track controller. The slave modport is the controller's view.
interface track_ingre_ctrl_if;
    logic       frame_tick;
    logic       start;
    logic       stop;
    logic       pause;
    logic       hit;
    logic [6:0] y_pos;
    logic       count;
    logic       active;
    logic       hit_ack;
    logic       miss_pulse;
    logic [7:0] score;

    modport master (
        output frame_tick, start, stop, pause, hit,
        input  y_pos, count, active, hit_ack, miss_pulse, score
    );

    modport slave (
        input  frame_tick, start, stop, pause, hit,
        output y_pos, count, active, hit_ack, miss_pulse, score
    );
endinterface

// File: rtl/track_ingre_ctrl.sv
// Falling-ingredient track controller: drops a glyph one row every
// STEP_FRAMES frames, scores catches, and flashes the glyph on a miss
// before respawning it at the top.
module track_ingre_ctrl #(
    parameter int STEP_FRAMES  = 2,
    parameter int Y_START      = 0,
    parameter int Y_MAX        = 59,
    parameter int FLASH_FRAMES = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    track_ingre_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, FALL, FLASH} state_t;

    state_t     state, state_nx;
    logic [7:0] div, div_nx;
    logic [7:0] fcnt, fcnt_nx;
    logic [7:0] score, score_nx;
    logic [6:0] y, y_nx;
    logic       cnt, cnt_nx;
    logic       act, act_nx;
    logic       ack, ack_nx;
    logic       miss, miss_nx;

    localparam logic [7:0] STEP_LAST  = 8'(STEP_FRAMES - 1);
    localparam logic [7:0] FLASH_LAST = 8'(FLASH_FRAMES - 1);
    localparam logic [6:0] Y_TOP      = 7'(Y_START);
    localparam logic [6:0] Y_BOT      = 7'(Y_MAX);

    // State and all outputs live in flops; outputs are the flop values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            div   <= '0;
            fcnt  <= '0;
            score <= '0;
            y     <= '0;
            cnt   <= 1'b0;
            act   <= 1'b0;
            ack   <= 1'b0;
            miss  <= 1'b0;
        end else begin
            state <= state_nx;
            div   <= div_nx;
            fcnt  <= fcnt_nx;
            score <= score_nx;
            y     <= y_nx;
            cnt   <= cnt_nx;
            act   <= act_nx;
            ack   <= ack_nx;
            miss  <= miss_nx;
        end
    end

    // Next-state logic: stop overrides everything, a catch beats a step,
    // and pause only freezes the falling phase (the flash keeps running).
    always_comb begin
        state_nx = state;
        div_nx   = div;
        fcnt_nx  = fcnt;
        score_nx = score;
        y_nx     = y;
        cnt_nx   = cnt;
        ack_nx   = 1'b0;
        miss_nx  = 1'b0;

        if (bus.stop) begin
            state_nx = IDLE;
            div_nx   = '0;
            fcnt_nx  = '0;
            y_nx     = '0;
            cnt_nx   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state_nx = FALL;
                        div_nx   = '0;
                        fcnt_nx  = '0;
                        score_nx = '0;
                        y_nx     = Y_TOP;
                        cnt_nx   = 1'b0;
                    end
                end
                FALL: begin
                    if (!bus.pause) begin
                        if (bus.hit) begin
                            ack_nx   = 1'b1;
                            score_nx = (score == 8'hFF) ? score : score + 8'd1;
                            y_nx     = Y_TOP;
                            div_nx   = '0;
                            cnt_nx   = ~cnt;
                        end else if (bus.frame_tick) begin
                            if (div == STEP_LAST) begin
                                div_nx = '0;
                                if (y < Y_BOT) begin
                                    y_nx = y + 7'd1;
                                end else begin
                                    miss_nx  = 1'b1;
                                    state_nx = FLASH;
                                    fcnt_nx  = '0;
                                end
                            end else begin
                                div_nx = div + 8'd1;
                            end
                        end
                    end
                end
                FLASH: begin
                    if (bus.frame_tick) begin
                        if (fcnt == FLASH_LAST) begin
                            state_nx = FALL;
                            fcnt_nx  = '0;
                            div_nx   = '0;
                            y_nx     = Y_TOP;
                            cnt_nx   = 1'b0;
                        end else begin
                            fcnt_nx = fcnt + 8'd1;
                            cnt_nx  = ~cnt;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end

        act_nx = (state_nx != IDLE);
    end

    assign bus.y_pos      = y;
    assign bus.count      = cnt;
    assign bus.active     = act;
    assign bus.hit_ack    = ack;
    assign bus.miss_pulse = miss;
    assign bus.score      = score;

endmodule

// File: tb/tb_track_ingre_ctrl.sv
// Directed bench: a vector table drives the default-parameter instance,
// hand-written sequences drive a small (Y_MAX=3, STEP_FRAMES=1) instance
// through miss, flash, saturation and asynchronous reset.
module tb_track_ingre_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    track_ingre_ctrl_if bus_d ();
    track_ingre_ctrl_if bus_s ();

    track_ingre_ctrl u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_d)
    );

    track_ingre_ctrl #(
        .STEP_FRAMES  (1),
        .Y_START      (0),
        .Y_MAX        (3),
        .FLASH_FRAMES (8)
    ) u_sm (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    typedef struct {
        logic st, sp, pa, hi, tk;
        int   y;
        logic c, a, ha, mp;
        int   sc;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc_d(input logic st, sp, pa, hi, tk);
        bus_d.start = st; bus_d.stop = sp; bus_d.pause = pa;
        bus_d.hit = hi; bus_d.frame_tick = tk;
        @(posedge clk); #1;
        bus_d.start = 0; bus_d.stop = 0; bus_d.hit = 0; bus_d.frame_tick = 0;
    endtask

    task automatic cyc_s(input logic st, sp, pa, hi, tk);
        bus_s.start = st; bus_s.stop = sp; bus_s.pause = pa;
        bus_s.hit = hi; bus_s.frame_tick = tk;
        @(posedge clk); #1;
        bus_s.start = 0; bus_s.stop = 0; bus_s.hit = 0; bus_s.frame_tick = 0;
    endtask

    task automatic chk_s(input string name, input int y, input int c, input int a,
                         input int ha, input int mp, input int sc);
        chk({name, ".y"},  int'(bus_s.y_pos), y);
        chk({name, ".c"},  int'(bus_s.count), c);
        chk({name, ".a"},  int'(bus_s.active), a);
        chk({name, ".ha"}, int'(bus_s.hit_ack), ha);
        chk({name, ".mp"}, int'(bus_s.miss_pulse), mp);
        chk({name, ".sc"}, int'(bus_s.score), sc);
    endtask

    initial begin
        //            st sp pa hi tk   y  c  a ha mp sc
        tbl[0]  = '{1, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0};  // start
        tbl[1]  = '{0, 0, 0, 0, 1,   0, 0, 1, 0, 0, 0};  // div 0->1
        tbl[2]  = '{0, 0, 0, 0, 1,   1, 0, 1, 0, 0, 0};  // step
        tbl[3]  = '{0, 0, 0, 0, 1,   1, 0, 1, 0, 0, 0};
        tbl[4]  = '{0, 0, 0, 0, 1,   2, 0, 1, 0, 0, 0};
        tbl[5]  = '{0, 0, 0, 1, 0,   0, 1, 1, 1, 0, 1};  // catch
        tbl[6]  = '{0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 1};  // ack is one cycle
        tbl[7]  = '{0, 0, 0, 0, 1,   0, 1, 1, 0, 0, 1};  // div 0->1
        tbl[8]  = '{0, 0, 1, 0, 1,   0, 1, 1, 0, 0, 1};  // paused tick
        tbl[9]  = '{0, 0, 1, 1, 0,   0, 1, 1, 0, 0, 1};  // paused hit
        tbl[10] = '{0, 0, 0, 0, 1,   1, 1, 1, 0, 0, 1};  // div held at 1 -> step
        tbl[11] = '{1, 0, 0, 0, 0,   1, 1, 1, 0, 0, 1};  // start ignored in FALL
        tbl[12] = '{0, 1, 0, 1, 0,   0, 0, 0, 0, 0, 1};  // stop beats hit
        tbl[13] = '{0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 1};  // idle tick
        tbl[14] = '{1, 0, 0, 0, 1,   0, 0, 1, 0, 0, 0};  // tick with start not counted
        tbl[15] = '{0, 0, 0, 0, 1,   0, 0, 1, 0, 0, 0};
        tbl[16] = '{0, 0, 0, 0, 1,   1, 0, 1, 0, 0, 0};

        bus_d.start = 0; bus_d.stop = 0; bus_d.pause = 0; bus_d.hit = 0; bus_d.frame_tick = 0;
        bus_s.start = 0; bus_s.stop = 0; bus_s.pause = 0; bus_s.hit = 0; bus_s.frame_tick = 0;

        #12;
        chk("rst.y",  int'(bus_d.y_pos), 0);
        chk("rst.a",  int'(bus_d.active), 0);
        chk("rst.sc", int'(bus_d.score), 0);
        chk_s("rst_s", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            cyc_d(tbl[i].st, tbl[i].sp, tbl[i].pa, tbl[i].hi, tbl[i].tk);
            chk($sformatf("vec%0d.y", i),  int'(bus_d.y_pos), tbl[i].y);
            chk($sformatf("vec%0d.c", i),  int'(bus_d.count), int'(tbl[i].c));
            chk($sformatf("vec%0d.a", i),  int'(bus_d.active), int'(tbl[i].a));
            chk($sformatf("vec%0d.ha", i), int'(bus_d.hit_ack), int'(tbl[i].ha));
            chk($sformatf("vec%0d.mp", i), int'(bus_d.miss_pulse), int'(tbl[i].mp));
            chk($sformatf("vec%0d.sc", i), int'(bus_d.score), tbl[i].sc);
        end

        // Long pause: ten ticks and a catch must change nothing.
        for (int i = 0; i < 10; i++) cyc_d(0, 0, 1, 0, 1);
        cyc_d(0, 0, 1, 1, 0);
        chk("pause.y",  int'(bus_d.y_pos), 1);
        chk("pause.ha", int'(bus_d.hit_ack), 0);
        chk("pause.sc", int'(bus_d.score), 0);
        chk("pause.c",  int'(bus_d.count), 0);
        cyc_d(0, 0, 0, 0, 1);
        chk("unpause1.y", int'(bus_d.y_pos), 1);
        cyc_d(0, 0, 0, 0, 1);
        chk("unpause2.y", int'(bus_d.y_pos), 2);

        // Small instance: fall to the bottom and miss on the 4th tick.
        cyc_s(1, 0, 0, 0, 0);
        chk_s("s_start", 0, 0, 1, 0, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            cyc_s(0, 0, 0, 0, 1);
            chk_s($sformatf("s_fall%0d", k), k, 0, 1, 0, 0, 0);
        end
        cyc_s(0, 0, 0, 0, 1);
        chk_s("s_miss", 3, 0, 1, 0, 1, 0);
        cyc_s(0, 0, 0, 1, 0);
        chk_s("s_flash_hit", 3, 0, 1, 0, 0, 0);

        // Flash: count toggles per tick, pause has no effect here.
        for (int k = 1; k <= 7; k++) begin
            cyc_s(0, 0, (k == 3), 0, 1);
            chk_s($sformatf("s_flash%0d", k), 3, k % 2, 1, 0, 0, 0);
        end
        bus_s.pause = 0;
        cyc_s(0, 0, 0, 0, 1);
        chk_s("s_respawn", 0, 0, 1, 0, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            cyc_s(0, 0, 0, 0, 1);
            chk_s($sformatf("s_refall%0d", k), k, 0, 1, 0, 0, 0);
        end

        // Catch on the bottom row in the same cycle as the miss step.
        cyc_s(0, 0, 0, 1, 1);
        chk_s("s_hit_vs_miss", 0, 1, 1, 1, 0, 1);

        // 255 more catches: score saturates, count returns to 0.
        for (int n = 0; n < 255; n++) cyc_s(0, 0, 0, 1, 0);
        chk_s("s_sat", 0, 0, 1, 1, 0, 255);
        cyc_s(0, 0, 0, 0, 0);
        chk_s("s_sat_idle", 0, 0, 1, 0, 0, 255);

        // Into flash again, then asynchronous reset between edges.
        for (int k = 0; k < 4; k++) cyc_s(0, 0, 0, 0, 1);
        chk("s_miss2.mp", int'(bus_s.miss_pulse), 1);
        for (int k = 0; k < 3; k++) cyc_s(0, 0, 0, 0, 1);
        chk("s_flash3.c", int'(bus_s.count), 1);
        #3 rst_n = 1'b0;
        #1;
        chk_s("s_async_rst", 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b1;
        cyc_s(1, 0, 0, 0, 0);
        chk_s("s_post_rst_start", 0, 0, 1, 0, 0, 0);
        cyc_s(0, 0, 0, 0, 1);
        chk_s("s_post_rst_fall", 1, 0, 1, 0, 0, 0);
        cyc_s(0, 1, 0, 0, 1);
        chk_s("s_stop", 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
